regfile_writeback: RTL and testbench

Writeback arbiter and destination scoreboard that drives the single write port of the register file (WriteEnable/WriteReg/WriteData). It merges ALU results (priority, ready/valid) and memory-load results (buffered in a 2-entry FIFO) into one registered write per cycle. It bounds memory starvation with a counter and tracks in-flight destinations so issue logic can detect read-after-write hazards.

---
 rtl/regfile_writeback.sv | 134 +++++++++++++
 tb/tb_regfile_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU results have priority, loads queue in a
// 2-entry FIFO with a bounded starvation window, plus a destination busy scoreboard.
`timescale 1ns/1ps
module regfile_writeback #(
    parameter int REG_ADDR_SIZE = 5,
    parameter int REG_SIZE      = 32,
    parameter int NUM_REGS      = 32,
    parameter int STARVE_MAX    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     AluValid,
    output logic                     AluReady,
    input  logic [REG_ADDR_SIZE-1:0] AluReg,
    input  logic [REG_SIZE-1:0]      AluData,
    input  logic                     MemValid,
    output logic                     MemReady,
    input  logic [REG_ADDR_SIZE-1:0] MemReg,
    input  logic [REG_SIZE-1:0]      MemData,
    input  logic                     IssueValid,
    input  logic [REG_ADDR_SIZE-1:0] IssueReg,
    input  logic [REG_ADDR_SIZE-1:0] QueryA,
    input  logic [REG_ADDR_SIZE-1:0] QueryB,
    output logic                     BusyA,
    output logic                     BusyB,
    output logic                     WriteEnable,
    output logic [REG_ADDR_SIZE-1:0] WriteReg,
    output logic [REG_SIZE-1:0]      WriteData
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [REG_ADDR_SIZE-1:0] fifo_reg_mem  [2];
    logic [REG_SIZE-1:0]      fifo_data_mem [2];
    logic                     wr_ptr_reg, rd_ptr_reg;
    logic [1:0]               count_reg;
    logic [SW-1:0]            starve_reg, starve_next;
    logic [NUM_REGS-1:0]      busy_reg, busy_next;

    logic fifo_empty, fifo_full, starved, push, mem_grant, alu_grant;
    logic [REG_ADDR_SIZE-1:0] grant_reg;
    logic [REG_SIZE-1:0]      grant_data;

    assign fifo_empty = (count_reg == 2'd0);
    assign fifo_full  = (count_reg == 2'd2);
    assign starved    = !fifo_empty && (starve_reg == STARVE_LIM);
    assign MemReady   = !fifo_full;
    assign AluReady   = !starved;
    assign push       = MemValid && !fifo_full;
    assign mem_grant  = !fifo_empty && (!AluValid || starved);
    assign alu_grant  = AluValid && !mem_grant;

    always_comb begin
        grant_reg  = AluReg;
        grant_data = AluData;
        if (mem_grant) begin
            grant_reg  = fifo_reg_mem[rd_ptr_reg];
            grant_data = fifo_data_mem[rd_ptr_reg];
        end
    end

    // The counter only measures ALU wins that actually delay a waiting load.
    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || mem_grant)
            starve_next = '0;
        else if (alu_grant && starve_reg != STARVE_LIM)
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_mem[wr_ptr_reg]  <= MemReg;
            fifo_data_mem[wr_ptr_reg] <= MemData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            starve_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= !wr_ptr_reg;
            if (mem_grant)
                rd_ptr_reg <= !rd_ptr_reg;
            case ({push, mem_grant})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            starve_reg <= starve_next;
        end
    end

    // Writes to x0 are dropped; address/data hold so the regfile port stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WriteEnable <= 1'b0;
            WriteReg    <= '0;
            WriteData   <= '0;
        end else if ((mem_grant || alu_grant) && grant_reg != '0) begin
            WriteEnable <= 1'b1;
            WriteReg    <= grant_reg;
            WriteData   <= grant_data;
        end else begin
            WriteEnable <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                // Issue set takes precedence over a retiring write to the same register.
                assign busy_next[gi] = (IssueValid && IssueReg == REG_ADDR_SIZE'(gi)) ||
                                       (busy_reg[gi] && !(WriteEnable && WriteReg == REG_ADDR_SIZE'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    assign BusyA = busy_reg[QueryA];
    assign BusyB = busy_reg[QueryB];
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes are queued by the stimulus
// and retired by a monitor that watches the registered write port.
`timescale 1ns/1ps
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        AluValid, AluReady, MemValid, MemReady, IssueValid;
    logic [4:0]  AluReg, MemReg, IssueReg, QueryA, QueryB, WriteReg;
    logic [31:0] AluData, MemData, WriteData;
    logic        BusyA, BusyB, WriteEnable;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    regfile_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
        .IssueValid(IssueValid), .IssueReg(IssueReg),
        .QueryA(QueryA), .QueryB(QueryB), .BusyA(BusyA), .BusyB(BusyB),
        .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("[TB] %s ok (%h)", name, act);
        end
    endfunction

    task automatic exp_push(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] r);
        AluValid = 1'b1;
        AluReg   = r;
        AluData  = 32'h100 + 32'(r);
    endtask

    task automatic mem(input logic [4:0] r);
        MemValid = 1'b1;
        MemReg   = r;
        MemData  = 32'hA000 + 32'(r);
    endtask

    // Scoreboard monitor: every write seen on the port must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && WriteEnable === 1'b1) begin
            wr_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got reg %0d data %h, required no write", WriteReg, WriteData);
            end else begin
                e = exp_q.pop_front();
                if (WriteReg !== e.r || WriteData !== e.d) begin
                    fails++;
                    $display("FAIL write: got reg %0d data %h, required reg %0d data %h",
                             WriteReg, WriteData, e.r, e.d);
                end else begin
                    $display("[TB] write reg %0d data %h ok", WriteReg, WriteData);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        AluValid = 0; AluReg = 0; AluData = 0;
        MemValid = 0; MemReg = 0; MemData = 0;
        IssueValid = 0; IssueReg = 0; QueryA = 0; QueryB = 0;
        repeat (2) tick();
        check("reset_we",     32'(WriteEnable), 32'd0);
        check("reset_wreg",   32'(WriteReg),    32'd0);
        check("reset_wdata",  WriteData,        32'd0);
        check("reset_memrdy", 32'(MemReady),    32'd1);
        check("reset_alurdy", 32'(AluReady),    32'd1);
        check("reset_busy",   32'(BusyA),       32'd0);
        rst_n = 1'b1;
        tick();

        // ALU single write with scoreboard set/clear
        IssueValid = 1; IssueReg = 3; tick(); IssueValid = 0;
        QueryA = 3; #1;
        check("busy3_set", 32'(BusyA), 32'd1);
        exp_push(5'd3, 32'hDEADBEEF);
        AluValid = 1; AluReg = 3; AluData = 32'hDEADBEEF;
        tick(); AluValid = 0; #1;
        check("alu_we",     32'(WriteEnable), 32'd1);
        check("busy3_held", 32'(BusyA),       32'd1);
        tick(); #1;
        check("busy3_clear", 32'(BusyA), 32'd0);

        // x0 suppression
        AluValid = 1; AluReg = 0; AluData = 32'h1234;
        tick(); AluValid = 0; #1;
        check("x0_we",        32'(WriteEnable), 32'd0);
        check("x0_hold_reg",  32'(WriteReg),    32'd3);
        check("x0_hold_data", WriteData,        32'hDEADBEEF);
        IssueValid = 1; IssueReg = 0; tick(); IssueValid = 0;
        QueryA = 0; #1;
        check("busy0", 32'(BusyA), 32'd0);

        // Starvation bound: load pushed alongside first ALU op waits 4 ALU grants
        for (int i = 11; i <= 15; i++) exp_push(5'(i), 32'h100 + 32'(i));
        exp_push(5'd7, 32'hA007);
        exp_push(5'd16, 32'h110);
        for (int i = 0; i < 5; i++) begin
            alu(5'(11 + i));
            if (i == 0) mem(5'd7); else MemValid = 0;
            tick();
        end
        alu(5'd16); #1;
        check("starve_alurdy_low", 32'(AluReady), 32'd0);
        tick(); #1;
        check("starve_alurdy_back", 32'(AluReady), 32'd1);
        tick(); AluValid = 0; tick();

        // FIFO full / backpressure, entries retire in push order
        exp_push(5'd1, 32'h101); exp_push(5'd2, 32'h102); exp_push(5'd3, 32'h103);
        exp_push(5'd4, 32'h104); exp_push(5'd5, 32'h105); exp_push(5'd20, 32'hA014);
        exp_push(5'd6, 32'h106); exp_push(5'd21, 32'hA015); exp_push(5'd22, 32'hA016);
        alu(5'd1); mem(5'd20); tick();
        alu(5'd2); mem(5'd21); tick();
        alu(5'd3); mem(5'd22); #1;
        check("full_memrdy", 32'(MemReady), 32'd0);
        tick();
        alu(5'd4); tick();
        alu(5'd5); tick();
        alu(5'd6); #1;
        check("full_alurdy", 32'(AluReady), 32'd0);
        check("full_pop_memrdy", 32'(MemReady), 32'd0);
        tick(); #1;
        check("full_slot_visible", 32'(MemReady), 32'd1);
        tick();
        AluValid = 0; MemValid = 0;
        repeat (3) tick();

        // Scoreboard collision: set wins over same-cycle retire
        IssueValid = 1; IssueReg = 9; tick(); IssueValid = 0;
        QueryB = 9; #1;
        check("busy9_set", 32'(BusyB), 32'd1);
        exp_push(5'd9, 32'h109);
        alu(5'd9); tick(); AluValid = 0;
        IssueValid = 1; IssueReg = 9; tick(); IssueValid = 0; #1;
        check("busy9_collide", 32'(BusyB), 32'd1);
        exp_push(5'd9, 32'h109);
        alu(5'd9); tick(); AluValid = 0; tick(); #1;
        check("busy9_clear", 32'(BusyB), 32'd0);

        // Reset mid-traffic: FIFO holds 2 loads, busy[5] set, write in flight
        IssueValid = 1; IssueReg = 5; tick(); IssueValid = 0;
        QueryA = 5; #1;
        check("busy5_set", 32'(BusyA), 32'd1);
        exp_push(5'd30, 32'h11E);
        alu(5'd30); mem(5'd24); tick();
        alu(5'd31); mem(5'd25); tick();
        AluValid = 0; MemValid = 0;
        rst_n = 1'b0; #1;
        check("rst_mid_we",     32'(WriteEnable), 32'd0);
        check("rst_mid_memrdy", 32'(MemReady),    32'd1);
        check("rst_mid_alurdy", 32'(AluReady),    32'd1);
        check("rst_mid_busy5",  32'(BusyA),       32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_no_write", 32'(WriteEnable), 32'd0);

        exp_push(5'd2, 32'h102);
        alu(5'd2); tick(); AluValid = 0;
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
